// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth control block: state encoding, Booth digit
// encoding and the default operand width.
package booth_pkg;

    localparam int unsigned BOOTH_N_DEF = 8;

    // One-hot so any corrupted pattern falls to the default arm and recovers to IDLE.
    typedef enum logic [7:0] {
        S_IDLE   = 8'b0000_0001,
        S_LOAD_Q = 8'b0000_0010,
        S_LOAD_M = 8'b0000_0100,
        S_EVAL   = 8'b0000_1000,
        S_SHIFT  = 8'b0001_0000,
        S_OUT_A  = 8'b0010_0000,
        S_OUT_Q  = 8'b0100_0000,
        S_DONE   = 8'b1000_0000
    } state_e;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        P1   = 3'd1,
        P2   = 3'd2,
        M1   = 3'd3,
        M2   = 3'd4
    } digit_e;

    function automatic digit_e booth_digit(input logic [2:0] trip);
        digit_e d;
        case (trip)
            3'b001, 3'b010: d = P1;
            3'b011:         d = P2;
            3'b100:         d = M2;
            3'b101, 3'b110: d = M1;
            default:        d = ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_r4_recoder.sv
// Combinational Booth recoder: maps the {Q1,Q0,Q-1} triplet to adder controls.
module booth_r4_recoder
    import booth_pkg::*;
(
    input  logic [2:0] i_q_trip,
    output logic       o_add_en,
    output logic       o_sub,
    output logic       o_dbl
);

    digit_e w_digit;

    assign w_digit  = booth_digit(i_q_trip);
    assign o_add_en = (w_digit != ZERO);
    assign o_sub    = (w_digit == M1) || (w_digit == M2);
    assign o_dbl    = (w_digit == P2) || (w_digit == M2);

endmodule

// File: rtl/booth_r4_ctrl.sv
// Radix-4 Booth multiplier sequencer: issues c0..c7 strobes and a done pulse.
// Optional sticky o_err for starts outside IDLE when BOOTH_R4_CTRL_ERR_EN is defined.
module booth_r4_ctrl
    import booth_pkg::*;
#(
    parameter int unsigned N = BOOTH_N_DEF
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [2:0] i_q_trip,
    output logic       o_c0,
    output logic       o_c1,
    output logic       o_c2,
    output logic       o_c3,
    output logic       o_c4,
    output logic       o_c5,
    output logic       o_c6,
    output logic       o_c7,
`ifdef BOOTH_R4_CTRL_ERR_EN
    output logic       o_err,
`endif
    output logic       o_done
);

    localparam int unsigned CNT_W = $clog2(N / 2);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N / 2 - 1);

    state_e           r_state;
    state_e           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             w_add_en;
    logic             w_sub;
    logic             w_dbl;

    booth_r4_recoder u_recoder (
        .i_q_trip (i_q_trip),
        .o_add_en (w_add_en),
        .o_sub    (w_sub),
        .o_dbl    (w_dbl)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_LOAD_Q) begin
                r_cnt <= '0;
            end else if (r_state == S_SHIFT) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Strobes decode from state so reset zeroes them in the same cycle.
    always_comb begin
        w_next = r_state;
        o_c0   = 1'b0;
        o_c1   = 1'b0;
        o_c2   = 1'b0;
        o_c3   = 1'b0;
        o_c4   = 1'b0;
        o_c5   = 1'b0;
        o_c6   = 1'b0;
        o_c7   = 1'b0;
        o_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next = S_LOAD_Q;
                end
            end
            S_LOAD_Q: begin
                o_c0   = 1'b1;
                w_next = S_LOAD_M;
            end
            S_LOAD_M: begin
                o_c1   = 1'b1;
                w_next = S_EVAL;
            end
            S_EVAL: begin
                o_c2   = w_add_en;
                o_c3   = w_add_en & w_sub;
                o_c4   = w_add_en & w_dbl;
                w_next = S_SHIFT;
            end
            S_SHIFT: begin
                o_c5   = 1'b1;
                w_next = (r_cnt == LAST_ITER) ? S_OUT_A : S_EVAL;
            end
            S_OUT_A: begin
                o_c6   = 1'b1;
                w_next = S_OUT_Q;
            end
            S_OUT_Q: begin
                o_c7   = 1'b1;
                w_next = S_DONE;
            end
            S_DONE: begin
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

`ifdef BOOTH_R4_CTRL_ERR_EN
    logic r_err;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_err <= 1'b0;
        end else if (i_start) begin
            r_err <= (r_state != S_IDLE);
        end
    end

    assign o_err = r_err;
`endif

endmodule

// File: tb/tb_booth_r4_ctrl.sv
// Bench for booth_r4_ctrl: N=8 and N=16 instances against a phase-count model.
module tb_booth_r4_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] q_trip;
    logic [8:0] o8;
    logic [8:0] o16;
    logic       err8;
    logic       err16;

    int checks   = 0;
    int failures = 0;

    // Model: phase 0 = idle, 1..N+5 = cycle index within an operation.
    int   ph[2]    = '{0, 0};
    logic err_m[2] = '{1'b0, 1'b0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    booth_r4_ctrl #(.N(8)) u_dut8 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_q_trip(q_trip),
        .o_c0(o8[8]), .o_c1(o8[7]), .o_c2(o8[6]), .o_c3(o8[5]), .o_c4(o8[4]),
        .o_c5(o8[3]), .o_c6(o8[2]), .o_c7(o8[1]),
`ifdef BOOTH_R4_CTRL_ERR_EN
        .o_err(err8),
`endif
        .o_done(o8[0])
    );

    booth_r4_ctrl #(.N(16)) u_dut16 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_q_trip(q_trip),
        .o_c0(o16[8]), .o_c1(o16[7]), .o_c2(o16[6]), .o_c3(o16[5]), .o_c4(o16[4]),
        .o_c5(o16[3]), .o_c6(o16[2]), .o_c7(o16[1]),
`ifdef BOOTH_R4_CTRL_ERR_EN
        .o_err(err16),
`endif
        .o_done(o16[0])
    );

`ifndef BOOTH_R4_CTRL_ERR_EN
    assign err8  = 1'b0;
    assign err16 = 1'b0;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected {c0,c1,c2,c3,c4,c5,c6,c7,done} from the operation phase and Booth digit value.
    function automatic logic [8:0] exp_out(input int p, input int n, input logic [2:0] q);
        logic [8:0] v;
        int d;
        v = '0;
        d = int'(q[1]) + int'(q[0]) - 2 * int'(q[2]);
        if (p == 1) v[8] = 1'b1;
        else if (p == 2) v[7] = 1'b1;
        else if (p >= 3 && p <= n + 2) begin
            if (((p - 3) % 2) == 0) begin
                v[6] = (d != 0);
                v[5] = (d < 0);
                v[4] = (d == 2) || (d == -2);
            end else begin
                v[3] = 1'b1;
            end
        end
        else if (p == n + 3) v[2] = 1'b1;
        else if (p == n + 4) v[1] = 1'b1;
        else if (p == n + 5) v[0] = 1'b1;
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            int nn;
            nn = (k == 0) ? 8 : 16;
            if (rst) begin
                ph[k]    = 0;
                err_m[k] = 1'b0;
            end else if (ph[k] == 0) begin
                if (start) begin
                    ph[k]    = 1;
                    err_m[k] = 1'b0;
                end
            end else begin
                if (start) err_m[k] = 1'b1;
                ph[k] = (ph[k] == nn + 5) ? 0 : ph[k] + 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("dut8_strobes", 32'(o8), 32'(exp_out(ph[0], 8, q_trip)));
        chk("dut16_strobes", 32'(o16), 32'(exp_out(ph[1], 16, q_trip)));
`ifdef BOOTH_R4_CTRL_ERR_EN
        chk("dut8_err", 32'(err8), 32'(err_m[0]));
        chk("dut16_err", 32'(err16), 32'(err_m[1]));
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One op from idle; returns done cycle, c5 count and the first-EVAL {c2,c3,c4} of dut8.
    task automatic run_op(input logic [2:0] q, output int d8, output int d16,
                          output int s8, output int s16, output logic [2:0] ev8);
        q_trip = q;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        d8 = -1; d16 = -1; s8 = 0; s16 = 0; ev8 = 3'b000;
        for (int c = 1; c <= 30; c++) begin
            if (c == 3) ev8 = {o8[6], o8[5], o8[4]};
            if (o8[0] && d8 < 0) d8 = c;
            if (o16[0] && d16 < 0) d16 = c;
            s8  += int'(o8[3]);
            s16 += int'(o16[3]);
            tick();
        end
    endtask

    initial begin
        logic [2:0] tbl[8];
        int d8, d16, s8, s16;
        logic [2:0] ev;
        int dt8[$];
        int dt16[$];

        tbl = '{3'b000, 3'b100, 3'b100, 3'b101, 3'b111, 3'b110, 3'b110, 3'b000};
        rst = 1'b1; start = 1'b0; q_trip = 3'b000;
        repeat (3) tick();
        chk("reset_out8", 32'(o8), 32'h0);
        chk("reset_out16", 32'(o16), 32'h0);
        rst = 1'b0;

        for (int q = 0; q < 8; q++) begin
            run_op(3'(q), d8, d16, s8, s16, ev);
            chk("done_lat8", 32'(d8), 32'd13);
            chk("done_lat16", 32'(d16), 32'd21);
            chk("c5_cnt8", 32'(s8), 32'd4);
            chk("c5_cnt16", 32'(s16), 32'd8);
            chk("eval_tbl", 32'(ev), 32'(tbl[q]));
        end

        // Reset during the second SHIFT, then a clean op.
        q_trip = 3'b000;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        repeat (5) tick();
        chk("c5_before_rst", 32'(o8[3]), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_out8", 32'(o8), 32'h0);
        chk("rst_mid_out16", 32'(o16), 32'h0);
        tick();
        rst = 1'b0;
        run_op(3'b000, d8, d16, s8, s16, ev);
        chk("post_rst_lat8", 32'(d8), 32'd13);
        chk("post_rst_lat16", 32'(d16), 32'd21);

        // Start held high: back-to-back ops.
        start = 1'b1;
        for (int c = 0; c < 70; c++) begin
            if (o8[0]) dt8.push_back(c);
            if (o16[0]) dt16.push_back(c);
            tick();
        end
        start = 1'b0;
        chk("held_done_cnt8", 32'(dt8.size() >= 4), 32'd1);
        chk("held_done_cnt16", 32'(dt16.size() >= 2), 32'd1);
        if (dt8.size() >= 2) chk("held_spacing8", 32'(dt8[1] - dt8[0]), 32'd14);
        if (dt16.size() >= 2) chk("held_spacing16", 32'(dt16[1] - dt16[0]), 32'd22);
        repeat (30) tick();

`ifdef BOOTH_R4_CTRL_ERR_EN
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("err_set", 32'(err8), 32'd1);
        d8 = -1;
        for (int c = 4; c <= 30; c++) begin
            if (o8[0] && d8 < 0) begin
                d8 = c;
                chk("err_at_done", 32'(err8), 32'd1);
            end
            tick();
        end
        chk("err_seq_lat8", 32'(d8), 32'd13);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("err_clear", 32'(err8), 32'd0);
        repeat (30) tick();
`endif

        // Random traffic with occasional resets.
        for (int c = 0; c < 1500; c++) begin
            q_trip = 3'($urandom);
            start  = ($urandom % 4) == 0;
            rst    = ($urandom % 97) == 0;
            tick();
        end
        rst = 1'b0;
        start = 1'b0;
        repeat (30) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
